// File: rtl/cipher_msg_feeder.sv
// Store-and-forward message source for stream_cipher: buffers host bytes and replays
// each complete message as a gap-free burst. Optional feature macro: KEY_ZEROIZE_EN.
module cipher_msg_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic [31:0] cfg_key,
  input  logic        cfg_encrypt,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [7:0]  c_data,
  output logic        c_valid,
  output logic        c_new_message,
  output logic        c_encrypt,
  output logic [31:0] c_key,
  output logic        busy,
  output logic        err_trunc,
  output logic [15:0] msg_count
);

  // Handshakes (s_* and cfg_*): a transfer occurs on the rising edge where valid && ready
  // are both high; the source holds its payload stable until then. The c_* side has no ready.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
`ifdef KEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_e;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   msgs_q;
  logic          discard_q;
  logic          err_trunc_q;

  state_e        state_q;
  logic [GW-1:0] gap_cnt_q;
  logic          first_q;
  logic          key_enc_q;
  logic [7:0]    c_data_q;
  logic          c_valid_q;
  logic          c_new_message_q;
  logic          c_encrypt_q;
  logic [31:0]   c_key_q;
  logic          busy_q;
  logic [15:0]   msg_count_q;

  logic       full, accept, push, trunc, entry_last, push_last;
  logic       pop, pop_last, hs;
  logic [8:0] pop_entry;

  always_comb begin
    full       = (count_q == FULL_CNT);
    s_ready    = !full || discard_q;
    accept     = s_valid && s_ready;
    push       = accept && !discard_q;
    // Filling the last slot with no complete message buffered would deadlock the host,
    // so the message is cut here and the remainder is swallowed.
    trunc      = push && (count_q == FULL_CNT - 1'b1) && !s_last && (msgs_q == '0);
    entry_last = s_last || trunc;
    push_last  = push && entry_last;
    pop        = (state_q == STREAM);
    pop_entry  = mem_q[rd_ptr_q];
    pop_last   = pop && pop_entry[8];
    cfg_ready  = (state_q == IDLE) && (msgs_q != '0);
    hs         = cfg_valid && cfg_ready;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {entry_last, s_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      msgs_q      <= '0;
      discard_q   <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      case ({push_last, pop_last})
        2'b10:   msgs_q <= msgs_q + 1'b1;
        2'b01:   msgs_q <= msgs_q - 1'b1;
        default: msgs_q <= msgs_q;
      endcase
      if (trunc) begin
        discard_q   <= 1'b1;
        err_trunc_q <= 1'b1;
      end else if (discard_q && accept && s_last) begin
        discard_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      gap_cnt_q       <= '0;
      first_q         <= 1'b0;
      key_enc_q       <= 1'b0;
      c_data_q        <= 8'd0;
      c_valid_q       <= 1'b0;
      c_new_message_q <= 1'b0;
      c_encrypt_q     <= 1'b0;
      c_key_q         <= 32'd0;
      busy_q          <= 1'b0;
      msg_count_q     <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          c_valid_q       <= 1'b0;
          c_new_message_q <= 1'b0;
          c_data_q        <= 8'd0;
          if (hs) begin
            c_key_q   <= cfg_key;
            key_enc_q <= cfg_encrypt;
            first_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          // The whole message is buffered, so one entry leaves every cycle.
          c_data_q        <= pop_entry[7:0];
          c_valid_q       <= 1'b1;
          c_new_message_q <= first_q;
          c_encrypt_q     <= key_enc_q;
          first_q         <= 1'b0;
          if (pop_entry[8]) begin
            msg_count_q <= msg_count_q + 16'd1;
            if (GAP_CYCLES > 0) begin
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
              if (ZEROIZE) begin
                c_key_q     <= 32'd0;
                c_encrypt_q <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          c_valid_q       <= 1'b0;
          c_new_message_q <= 1'b0;
          c_data_q        <= 8'd0;
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (ZEROIZE) begin
              c_key_q     <= 32'd0;
              c_encrypt_q <= 1'b0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign c_data        = c_data_q;
  assign c_valid       = c_valid_q;
  assign c_new_message = c_new_message_q;
  assign c_encrypt     = c_encrypt_q;
  assign c_key         = c_key_q;
  assign busy          = busy_q;
  assign err_trunc     = err_trunc_q;
  assign msg_count     = msg_count_q;

endmodule

// File: tb/tb_cipher_msg_feeder.sv
// Bench for cipher_msg_feeder: directed messages, a message-level output model checked
// every cycle, and literal expectations per scenario. Honours KEY_ZEROIZE_EN.
module tb_cipher_msg_feeder;
  localparam int DEPTH = 16;
  localparam int GAP   = 4;
  localparam int CLK_P = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] cfg_key = 32'd0;
  logic        cfg_encrypt = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  c_data;
  logic        c_valid;
  logic        c_new_message;
  logic        c_encrypt;
  logic [31:0] c_key;
  logic        busy;
  logic        err_trunc;
  logic [15:0] msg_count;

  cipher_msg_feeder #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .cfg_key(cfg_key), .cfg_encrypt(cfg_encrypt), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .c_data(c_data), .c_valid(c_valid), .c_new_message(c_new_message),
    .c_encrypt(c_encrypt), .c_key(c_key),
    .busy(busy), .err_trunc(err_trunc), .msg_count(msg_count)
  );

  // ---------------- clock / reset ----------------
  always #(CLK_P/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  int          exp_len_q[$];
  logic [31:0] exp_key_q[$];
  logic        exp_enc_q[$];

  int          pos = 0, cur_len = 0, idle = 0, model_count = 0;
  bit          have_prev = 1'b0;
  logic [31:0] cur_key = 32'd0;
  logic        cur_enc = 1'b0;
  logic [7:0]  burst_first = 8'd0, burst_last = 8'd0;
  logic [31:0] burst_key = 32'd0;
  int          burst_seen_len = 0, burst_start_cyc = 0, last_gap = 0;
  int          last_hs_cyc = 0;

  logic [7:0]  msg_buf [0:31];
  int          stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); exp_len_q.delete(); exp_key_q.delete(); exp_enc_q.delete();
      pos = 0; cur_len = 0; idle = 0; model_count = 0; have_prev = 1'b0;
    end else begin
      if (c_valid) begin
        if (pos == 0) begin
          if (exp_len_q.size() == 0 || exp_key_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_burst actual=c_valid_1 required=no_burst_pending t=%0t", $time);
          end else begin
            cur_len = exp_len_q.pop_front();
            cur_key = exp_key_q.pop_front();
            cur_enc = exp_enc_q.pop_front();
            if (have_prev) begin
              checks++;
              if (idle < GAP + 1) begin
                errors++;
                $display("FAIL burst_gap actual=%0d required>=%0d t=%0t", idle, GAP + 1, $time);
              end
            end
            last_gap = idle;
            burst_first = c_data; burst_key = c_key;
            burst_seen_len = 0; burst_start_cyc = cyc;
          end
        end
        if (cur_len != 0) begin
          chk("data", c_data, exp_q.pop_front());
          chk("new_message", c_new_message, pos == 0);
          chk("key", c_key, cur_key);
          chk("encrypt", c_encrypt, cur_enc);
          chk("busy_in_burst", busy, 1'b1);
          pos++; burst_seen_len++; burst_last = c_data;
          if (pos == cur_len) begin
            pos = 0; cur_len = 0; model_count++; have_prev = 1'b1; idle = 0;
          end
        end
      end else begin
        if (pos != 0) chk("bubble_in_burst", c_valid, 1'b1);
        chk("idle_data", c_data, 8'd0);
        chk("idle_new_message", c_new_message, 1'b0);
        idle++;
        if (have_prev && idle < GAP) begin
          chk("gap_key_hold", c_key, cur_key);
          chk("gap_enc_hold", c_encrypt, cur_enc);
          chk("gap_busy", busy, 1'b1);
        end
        if (have_prev && idle == GAP) chk("busy_drop", busy, 1'b0);
`ifdef KEY_ZEROIZE_EN
        if (have_prev && idle == GAP) begin
          chk("zeroize_key", c_key, 32'd0);
          chk("zeroize_enc", c_encrypt, 1'b0);
        end
`else
        if (have_prev && idle >= GAP && exp_key_q.size() == 0) begin
          chk("idle_key_hold", c_key, cur_key);
          chk("idle_enc_hold", c_encrypt, cur_enc);
        end
`endif
      end
      chk("msg_count", msg_count, model_count[15:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_msg(input int len);
    int keep;
    keep = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < keep; i++) exp_q.push_back(msg_buf[i]);
    exp_len_q.push_back(keep);
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      bit acc;
      int w;
      s_valid = 1'b1; s_data = msg_buf[i]; s_last = (i == len - 1);
      acc = 1'b0; w = 0;
      while (!acc) begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1;
        if (!acc) begin
          stalls++; w++;
          if (w > 200) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=s_ready_low required=accept byte=%0d", i);
            s_valid = 1'b0; s_last = 1'b0;
            return;
          end
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] key, input logic enc);
    bit acc;
    int w;
    cfg_key = key; cfg_encrypt = enc; cfg_valid = 1'b1;
    acc = 1'b0; w = 0;
    while (!acc) begin
      @(negedge clk); acc = cfg_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_key_q.push_back(key); exp_enc_q.push_back(enc);
        last_hs_cyc = cyc;
      end else begin
        w++;
        if (w > 300) begin
          checks++; errors++;
          $display("FAIL header_timeout actual=cfg_ready_low required=handshake key=0x%0h", key);
          break;
        end
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && pos == 0 && busy == 1'b0)) begin
      w++;
      if (w > 400) begin
        checks++; errors++;
        $display("FAIL %s_drain actual=pending_%0d_busy_%0d required=drained", tag, exp_q.size(), busy);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c_valid", c_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_err", err_trunc, 1'b0);
    chk("post_rst_key", c_key, 32'd0);
    chk("post_rst_count", msg_count, 16'd0);

    // Basic 3-byte message; a header with nothing buffered must wait.
    @(negedge clk);
    chk("hdr_wait_empty", cfg_ready, 1'b0);
    @(posedge clk); #1;
    msg_buf[0] = 8'h11; msg_buf[1] = 8'h22; msg_buf[2] = 8'h33;
    send_msg(3);
    @(negedge clk);
    chk("basic_cfg_ready", cfg_ready, 1'b1);
    @(posedge clk); #1;
    send_header(32'hDEADBEEF, 1'b1);
    wait_done("basic");
    chk("basic_first", burst_first, 8'h11);
    chk("basic_last", burst_last, 8'h33);
    chk("basic_len", burst_seen_len, 3);
    chk("basic_key", burst_key, 32'hDEADBEEF);
    chk("basic_latency", burst_start_cyc - last_hs_cyc, 1);
    chk("basic_count", msg_count, 16'd1);

    // Back-to-back: both messages queued, second header waiting.
    msg_buf[0] = 8'hA1; msg_buf[1] = 8'hA2; send_msg(2);
    msg_buf[0] = 8'hB1; msg_buf[1] = 8'hB2; send_msg(2);
    send_header(32'h11112222, 1'b0);
    send_header(32'h33334444, 1'b1);
    wait_done("b2b");
    chk("b2b_gap", last_gap, GAP + 1);
    chk("b2b_first", burst_first, 8'hB1);
    chk("b2b_key", burst_key, 32'h33334444);
    chk("b2b_count", msg_count, 16'd3);

    // Truncation: 20-byte message into an empty 16-entry FIFO.
    chk("trunc_err_before", err_trunc, 1'b0);
    for (int i = 0; i < 20; i++) msg_buf[i] = 8'h40 + 8'(i);
    send_msg(20);
    chk("trunc_no_stall", stalls, 0);
    chk("trunc_err_after", err_trunc, 1'b1);
    @(negedge clk);
    chk("trunc_full_sready", s_ready, 1'b0);
    @(posedge clk); #1;
    send_header(32'hCAFEF00D, 1'b0);
    wait_done("trunc");
    chk("trunc_len", burst_seen_len, 16);
    chk("trunc_last", burst_last, 8'h4F);
    msg_buf[0] = 8'hC1; msg_buf[1] = 8'hC2; send_msg(2);
    send_header(32'h0BADC0DE, 1'b1);
    wait_done("post_trunc");
    chk("post_trunc_first", burst_first, 8'hC1);
    chk("post_trunc_len", burst_seen_len, 2);

    // Pushes of message 2 overlap the streaming of message 1.
    for (int i = 0; i < 6; i++) msg_buf[i] = 8'h61 + 8'(i);
    send_msg(6);
    send_header(32'h5555AAAA, 1'b0);
    for (int i = 0; i < 5; i++) msg_buf[i] = 8'h71 + 8'(i);
    send_msg(5);
    send_header(32'h12345678, 1'b1);
    wait_done("overlap");
    chk("overlap_first", burst_first, 8'h71);
    chk("overlap_len", burst_seen_len, 5);
    chk("overlap_fifo_empty", cfg_ready, 1'b0);
    chk("overlap_count", msg_count, 16'd7);

    // Reset asserted on the second byte of a 5-byte burst.
    for (int i = 0; i < 5; i++) msg_buf[i] = 8'h81 + 8'(i);
    send_msg(5);
    send_header(32'h99998888, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
        @(negedge clk);
        if (c_valid && !c_new_message) seen = 1'b1;
      end
      chk("rst_mid_second_byte_seen", seen, 1'b1);
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_c_valid", c_valid, 1'b0);
    chk("rst_mid_c_key", c_key, 32'd0);
    chk("rst_mid_s_ready", s_ready, 1'b1);
    chk("rst_mid_cfg_ready", cfg_ready, 1'b0);
    chk("rst_mid_count", msg_count, 16'd0);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1-byte message, then key state once back in IDLE.
    msg_buf[0] = 8'hEE;
    send_msg(1);
    send_header(32'hA5A5A5A5, 1'b1);
    wait_done("one_byte");
    chk("one_byte_len", burst_seen_len, 1);
    chk("one_byte_data", burst_last, 8'hEE);
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef KEY_ZEROIZE_EN
    chk("idle_key_final", c_key, 32'd0);
    chk("idle_enc_final", c_encrypt, 1'b0);
`else
    chk("idle_key_final", c_key, 32'hA5A5A5A5);
    chk("idle_enc_final", c_encrypt, 1'b1);
`endif
    chk("final_count", msg_count, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- final report on runaway ----------------
  initial begin
    #(CLK_P * 20000);
    errors++;
    $display("FAIL watchdog actual=still_running required=finished t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
